// File: rtl/sound_noise_sync_if.sv
// Noise channel register/tick bundle between the APU register file and the noise channel.
// master: register file and tick generator side; slave: the noise channel.
interface sound_noise_sync_if #(
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned VOL_W   = 4,
  parameter int unsigned SWEEP_W = 3
);
  logic               tick_length;
  logic               tick_env;
  logic               start;
  logic [LEN_W-1:0]   length;
  logic               single;
  logic [VOL_W-1:0]   initial_volume;
  logic               envelope_increasing;
  logic [SWEEP_W-1:0] num_envelope_sweeps;
  logic [3:0]         shift_clock_freq;
  logic               counter_width;
  logic [2:0]         freq_dividing_ratio;
  logic [VOL_W-1:0]   level;
  logic               enable;

  modport master (
    output tick_length, tick_env, start, length, single, initial_volume,
           envelope_increasing, num_envelope_sweeps, shift_clock_freq, counter_width,
           freq_dividing_ratio,
    input  level, enable
  );

  modport slave (
    input  tick_length, tick_env, start, length, single, initial_volume,
           envelope_increasing, num_envelope_sweeps, shift_clock_freq, counter_width,
           freq_dividing_ratio,
    output level, enable
  );
endinterface

// File: rtl/sound_noise_sync.sv
// Synchronous APU noise channel: LFSR noise source, shift-rate timer, volume envelope and
// length counter, all advanced by single-cycle tick enables.
// Build option: SOUND_NOISE_LIVE_RELOAD_EN samples rate settings at every timer reload
// instead of only at trigger.
module sound_noise_sync #(
  parameter int unsigned LFSR_W  = 15,
  parameter int unsigned SHORT_W = 7,
  parameter int unsigned LEN_W   = 6,
  parameter int unsigned VOL_W   = 4,
  parameter int unsigned SWEEP_W = 3
) (
  input logic                clk,
  input logic                rst,
  sound_noise_sync_if.slave  bus
);

  // Largest period is 112 << 13, which needs 20 bits.
  localparam int unsigned TimerW = 20;

  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic [SWEEP_W-1:0] env_cnt_q, env_cnt_d;
  logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
  logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               env_inc_q, env_inc_d;
  logic               single_q, single_d;
  logic               cw_q, cw_d;
  logic               enable_q, enable_d;
  logic [VOL_W-1:0]   level_q, level_d;
`ifndef SOUND_NOISE_LIVE_RELOAD_EN
  logic [2:0]         r_q, r_d;
  logic [3:0]         s_q, s_d;
`endif

  logic dac_on;
  logic trigger;

  function automatic logic [TimerW-1:0] period_f(logic [2:0] r, logic [3:0] s);
    logic [TimerW-1:0] d;
    d = (r == 3'd0) ? TimerW'(8) : TimerW'({r, 4'b0000});
    return d << s;
  endfunction

  // Shift codes 14 and 15 stop the noise clock entirely.
  function automatic logic frozen_f(logic [3:0] s);
    return s[3:1] == 3'b111;
  endfunction

  function automatic logic [LFSR_W-1:0] shift_f(logic [LFSR_W-1:0] v, logic short_mode);
    logic              x;
    logic [LFSR_W-1:0] n;
    x = v[0] ^ v[1];
    n = {x, v[LFSR_W-1:1]};
    if (short_mode) n[SHORT_W-1] = x;
    return n;
  endfunction

  assign dac_on  = (bus.initial_volume != '0) | bus.envelope_increasing;
  assign trigger = bus.start & dac_on;

  // Next-state: trigger load has priority over every tick and timer event in its cycle.
  always_comb begin
    lfsr_d    = lfsr_q;
    vol_d     = vol_q;
    env_cnt_d = env_cnt_q;
    sweeps_d  = sweeps_q;
    len_cnt_d = len_cnt_q;
    timer_d   = timer_q;
    env_inc_d = env_inc_q;
    single_d  = single_q;
    cw_d      = cw_q;
    enable_d  = enable_q;
`ifndef SOUND_NOISE_LIVE_RELOAD_EN
    r_d       = r_q;
    s_d       = s_q;
`endif
    level_d   = (enable_q & ~lfsr_q[0]) ? vol_q : '0;

    if (trigger) begin
      lfsr_d    = '1;
      vol_d     = bus.initial_volume;
      env_cnt_d = bus.num_envelope_sweeps;
      sweeps_d  = bus.num_envelope_sweeps;
      env_inc_d = bus.envelope_increasing;
      single_d  = bus.single;
      cw_d      = bus.counter_width;
`ifndef SOUND_NOISE_LIVE_RELOAD_EN
      r_d       = bus.freq_dividing_ratio;
      s_d       = bus.shift_clock_freq;
`endif
      // A retrigger in one-shot mode continues an unfinished length count.
      if (len_cnt_q == '0 || !bus.single) len_cnt_d = bus.length;
      timer_d   = frozen_f(bus.shift_clock_freq) ? '0 :
                  period_f(bus.freq_dividing_ratio, bus.shift_clock_freq);
      enable_d  = 1'b1;
    end else begin
      // A zero timer means no trigger yet or a frozen rate.
      if (timer_q != '0) begin
        if (timer_q == TimerW'(1)) begin
          lfsr_d = shift_f(lfsr_q, cw_q);
`ifdef SOUND_NOISE_LIVE_RELOAD_EN
          cw_d    = bus.counter_width;
          timer_d = frozen_f(bus.shift_clock_freq) ? '0 :
                    period_f(bus.freq_dividing_ratio, bus.shift_clock_freq);
`else
          timer_d = period_f(r_q, s_q);
`endif
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      if (bus.tick_env && sweeps_q != '0) begin
        if (env_cnt_q <= SWEEP_W'(1)) begin
          env_cnt_d = sweeps_q;
          if (env_inc_q && vol_q != '1)        vol_d = vol_q + VOL_W'(1);
          else if (!env_inc_q && vol_q != '0)  vol_d = vol_q - VOL_W'(1);
        end else begin
          env_cnt_d = env_cnt_q - SWEEP_W'(1);
        end
      end

      if (bus.tick_length && single_q && enable_q) begin
        len_cnt_d = len_cnt_q + LEN_W'(1);
        if (len_cnt_q == '1) enable_d = 1'b0;
      end
    end

    if (!dac_on) enable_d = 1'b0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q    <= '1;
      vol_q     <= '0;
      env_cnt_q <= '0;
      sweeps_q  <= '0;
      len_cnt_q <= '0;
      timer_q   <= '0;
      env_inc_q <= 1'b0;
      single_q  <= 1'b0;
      cw_q      <= 1'b0;
      enable_q  <= 1'b0;
      level_q   <= '0;
`ifndef SOUND_NOISE_LIVE_RELOAD_EN
      r_q       <= '0;
      s_q       <= '0;
`endif
    end else begin
      lfsr_q    <= lfsr_d;
      vol_q     <= vol_d;
      env_cnt_q <= env_cnt_d;
      sweeps_q  <= sweeps_d;
      len_cnt_q <= len_cnt_d;
      timer_q   <= timer_d;
      env_inc_q <= env_inc_d;
      single_q  <= single_d;
      cw_q      <= cw_d;
      enable_q  <= enable_d;
      level_q   <= level_d;
`ifndef SOUND_NOISE_LIVE_RELOAD_EN
      r_q       <= r_d;
      s_q       <= s_d;
`endif
    end
  end

  assign bus.level  = level_q;
  assign bus.enable = enable_q;

endmodule

// File: tb/tb_sound_noise_sync.sv
// Self-checking bench for sound_noise_sync: directed scenarios with hand-derived values plus
// randomized episodes compared every cycle against a behavioural channel model.
module tb_sound_noise_sync;

  localparam int LW = 15;
  localparam int SW = 7;
  localparam int NW = 6;
  localparam int VW = 4;
  localparam int EW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  sound_noise_sync_if #(.LEN_W(NW), .VOL_W(VW), .SWEEP_W(EW)) bus_if ();

  sound_noise_sync #(
    .LFSR_W (LW),
    .SHORT_W(SW),
    .LEN_W  (NW),
    .VOL_W  (VW),
    .SWEEP_W(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Reference model state, plain integers.
  int m_lfsr, m_vol, m_env, m_len, m_wait, m_en, m_level;
  int m_r, m_s, m_cw, m_single, m_inc, m_sweeps;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int period_of(input int r, input int s);
    return (r == 0 ? 8 : 16 * r) * (1 << s);
  endfunction

  function automatic int next_noise(input int v, input int short_mode);
    int x;
    x = (v ^ (v >> 1)) & 1;
    v = (v >> 1) | (x << (LW - 1));
    if (short_mode != 0) v = (v & ~(1 << (SW - 1))) | (x << (SW - 1));
    return v;
  endfunction

  // m_wait counts cycles left until the next shift; 0 means the noise clock is stopped.
  task automatic model_step();
    int dac, nl;
    if (rst) begin
      m_lfsr = (1 << LW) - 1; m_vol = 0; m_env = 0; m_len = 0; m_wait = 0; m_en = 0;
      m_level = 0; m_r = 0; m_s = 0; m_cw = 0; m_single = 0; m_inc = 0; m_sweeps = 0;
      return;
    end
    dac = (bus_if.initial_volume != 0 || bus_if.envelope_increasing) ? 1 : 0;
    nl  = (m_en != 0 && m_lfsr % 2 == 0) ? m_vol : 0;
    if (bus_if.start && dac != 0) begin
      m_lfsr   = (1 << LW) - 1;
      m_vol    = int'(bus_if.initial_volume);
      m_sweeps = int'(bus_if.num_envelope_sweeps);
      m_env    = m_sweeps;
      m_inc    = int'(bus_if.envelope_increasing);
      m_single = int'(bus_if.single);
      m_cw     = int'(bus_if.counter_width);
      m_r      = int'(bus_if.freq_dividing_ratio);
      m_s      = int'(bus_if.shift_clock_freq);
      if (m_len == 0 || !bus_if.single) m_len = int'(bus_if.length);
      m_wait   = (m_s >= 14) ? 0 : period_of(m_r, m_s);
      m_en     = 1;
    end else begin
      if (m_wait == 1) begin
        m_lfsr = next_noise(m_lfsr, m_cw);
`ifdef SOUND_NOISE_LIVE_RELOAD_EN
        m_r  = int'(bus_if.freq_dividing_ratio);
        m_s  = int'(bus_if.shift_clock_freq);
        m_cw = int'(bus_if.counter_width);
`endif
        m_wait = (m_s >= 14) ? 0 : period_of(m_r, m_s);
      end else if (m_wait > 1) begin
        m_wait--;
      end
      if (bus_if.tick_env && m_sweeps != 0) begin
        if (m_env <= 1) begin
          m_env = m_sweeps;
          if (m_inc != 0) m_vol = (m_vol < (1 << VW) - 1) ? m_vol + 1 : m_vol;
          else            m_vol = (m_vol > 0) ? m_vol - 1 : 0;
        end else begin
          m_env--;
        end
      end
      if (bus_if.tick_length && m_single != 0 && m_en != 0) begin
        m_len = (m_len + 1) % (1 << NW);
        if (m_len == 0) m_en = 0;
      end
    end
    if (dac == 0) m_en = 0;
    m_level = nl;
  endtask

  // One clock: apply strobes, step the model at the edge, compare #1 later.
  task automatic cyc(input bit st, input bit tl, input bit te);
    bus_if.start       = st;
    bus_if.tick_length = tl;
    bus_if.tick_env    = te;
    @(posedge clk);
    model_step();
    #1;
    check_eq("level", int'(bus_if.level), m_level);
    check_eq("enable", int'(bus_if.enable), m_en);
    bus_if.start       = 1'b0;
    bus_if.tick_length = 1'b0;
    bus_if.tick_env    = 1'b0;
  endtask

  task automatic setup(input int vol, input bit inc, input int sw, input int r, input int s,
                       input bit cw, input bit sgl, input int len);
    bus_if.initial_volume      = VW'(vol);
    bus_if.envelope_increasing = inc;
    bus_if.num_envelope_sweeps = EW'(sw);
    bus_if.freq_dividing_ratio = 3'(r);
    bus_if.shift_clock_freq    = 4'(s);
    bus_if.counter_width       = cw;
    bus_if.single              = sgl;
    bus_if.length              = NW'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    setup(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    bus_if.start = 1'b0; bus_if.tick_length = 1'b0; bus_if.tick_env = 1'b0;

    // Reset state.
    do_reset();
    check_eq("rst_level", int'(bus_if.level), 0);
    check_eq("rst_enable", int'(bus_if.enable), 0);

    // Long mode, period 8: bit 0 clears on the 15th shift (edge 120), level one edge later.
    setup(15, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("trig_enable", int'(bus_if.enable), 1);
    for (int i = 1; i <= 121; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (i == 120) check_eq("long_pre15", int'(bus_if.level), 0);
      if (i == 121) check_eq("long_post15", int'(bus_if.level), 15);
    end

    // Short mode, period 64: level first nonzero after the 7th shift.
    do_reset();
    setup(9, 1'b0, 0, 1, 2, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 449; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (i == 448) check_eq("short_pre7", int'(bus_if.level), 0);
      if (i == 449) check_eq("short_post7", int'(bus_if.level), 9);
    end

    // One-shot length 62: expires on the 2nd tick.
    do_reset();
    setup(15, 1'b0, 0, 0, 0, 1'b0, 1'b1, 62);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("len62_tick1", int'(bus_if.enable), 1);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("len62_tick2", int'(bus_if.enable), 0);

    // Length 0: expires on the 64th tick.
    do_reset();
    setup(15, 1'b0, 0, 0, 0, 1'b0, 1'b1, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (i == 63) check_eq("len0_tick63", int'(bus_if.enable), 1);
      if (i == 64) check_eq("len0_tick64", int'(bus_if.enable), 0);
    end

    // Start together with tick_length: the tick is dropped, full 2 ticks still needed.
    do_reset();
    setup(15, 1'b0, 0, 0, 0, 1'b0, 1'b1, 62);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("st_tl_tick1", int'(bus_if.enable), 1);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("st_tl_tick2", int'(bus_if.enable), 0);

    // Envelope down from 2, observed once the LFSR output bit is 0.
    do_reset();
    setup(2, 1'b0, 1, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 121; i++) cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_dn_start", int'(bus_if.level), 2);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_dn_1", int'(bus_if.level), 1);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_dn_0", int'(bus_if.level), 0);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_dn_hold", int'(bus_if.level), 0);

    // Envelope up from 14 saturates at 15.
    do_reset();
    setup(14, 1'b1, 1, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 121; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_up_15", int'(bus_if.level), 15);
    cyc(1'b0, 1'b0, 1'b1); cyc(1'b0, 1'b0, 1'b0);
    check_eq("env_up_sat", int'(bus_if.level), 15);

    // DAC off: start ignored; clearing the DAC mid-note drops enable next cycle.
    do_reset();
    setup(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("dac_off_start", int'(bus_if.enable), 0);
    setup(5, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("dac_on_note", int'(bus_if.enable), 1);
    bus_if.initial_volume = '0;
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("dac_cleared", int'(bus_if.enable), 0);

    // Rate change mid-note: s goes 0 -> 1 three cycles after trigger.
    do_reset();
    setup(15, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 233; i++) begin
      if (i == 3) bus_if.shift_clock_freq = 4'd1;
      cyc(1'b0, 1'b0, 1'b0);
`ifdef SOUND_NOISE_LIVE_RELOAD_EN
      // First period 8 completes, then 16: 15th shift at 8 + 14*16 = 232.
      if (i == 232) check_eq("live_pre15", int'(bus_if.level), 0);
      if (i == 233) check_eq("live_post15", int'(bus_if.level), 15);
`else
      if (i == 120) check_eq("latched_pre15", int'(bus_if.level), 0);
      if (i == 121) check_eq("latched_post15", int'(bus_if.level), 15);
`endif
    end

    // Randomized episodes checked every cycle against the model.
    for (int ep = 0; ep < 30; ep++) begin
      if ($urandom_range(3) == 0) do_reset();
      setup($urandom_range(15), 1'($urandom_range(1)), $urandom_range(7), $urandom_range(7),
            ($urandom_range(9) == 0) ? 14 + $urandom_range(1) : $urandom_range(3),
            1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(63));
      cyc(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(99) == 0) begin
          bus_if.initial_volume      = VW'($urandom_range(15));
          bus_if.envelope_increasing = 1'($urandom_range(1));
        end
        if ($urandom_range(49) == 0) begin
          bus_if.shift_clock_freq    = 4'($urandom_range(3));
          bus_if.freq_dividing_ratio = 3'($urandom_range(7));
          bus_if.counter_width       = 1'($urandom_range(1));
          bus_if.num_envelope_sweeps = EW'($urandom_range(7));
          bus_if.single              = 1'($urandom_range(1));
          bus_if.length              = NW'($urandom_range(63));
        end
        cyc(1'($urandom_range(199) == 0), 1'($urandom_range(7) == 0),
            1'($urandom_range(7) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
